// File: rtl/lcd_text_sequencer.sv
// Streams a 2x16 character buffer to an LCD command executor as clear / set-address /
// write-char commands, optionally followed by a 2 s wait, with an accept timeout.
module lcd_text_sequencer #(
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       HOLD,
    input  logic       WR_EN,
    input  logic [4:0] WR_ADDR,
    input  logic [7:0] WR_DATA,
    input  logic       EXE_RDY,
    output logic       EXE_ENB,
    output logic [3:0] EXE_OP,
    output logic [7:0] EXE_DATA,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR
);
    localparam logic [3:0] OP_CLR  = 4'h0;
    localparam logic [3:0] OP_WR   = 4'h1;
    localparam logic [3:0] OP_ADDR = 4'h3;
    localparam logic [3:0] OP_WAIT = 4'h4;
    localparam logic [3:0] OP_NOP  = 4'hF;
    localparam int         AW       = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
    localparam logic [AW-1:0] ACC_LAST = AW'(ACK_TIMEOUT - 1);
    localparam logic [5:0] STEP_LAST = 6'd35;

    typedef enum logic [2:0] {S_BOOT, S_IDLE, S_LOAD, S_ISSUE, S_EXEC, S_DONE} state_t;

    state_t        state, state_nxt;
    logic [5:0]    step, step_nxt;
    logic [AW-1:0] acc, acc_nxt;
    logic [3:0]    op_nxt;
    logic [7:0]    data_nxt;
    logic          hold, hold_nxt;
    logic          err_nxt, done_nxt;
    logic [7:0]    char_buf [32];

    logic          cmd_valid;
    logic [3:0]    cmd_op;
    logic [7:0]    cmd_data;
    logic [4:0]    buf_idx;

    assign BUSY = (state != S_IDLE);

    // Line 2 characters sit one step further along because of the second address command;
    // the 5-bit wraparound of step-3 still lands on 16..31.
    always_comb begin
        cmd_valid = 1'b1;
        cmd_op    = OP_WR;
        cmd_data  = 8'h00;
        buf_idx   = (step <= 6'd17) ? (step[4:0] - 5'd2) : (step[4:0] - 5'd3);
        if (step == 6'd0) begin
            cmd_op = OP_CLR;
        end else if (step == 6'd1) begin
            cmd_op = OP_ADDR;
        end else if (step == 6'd18) begin
            cmd_op   = OP_ADDR;
            cmd_data = 8'h40;
        end else if (step == STEP_LAST) begin
            cmd_op    = OP_WAIT;
            cmd_valid = hold;
        end else begin
            cmd_data = char_buf[buf_idx];
        end
    end

    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        acc_nxt   = acc;
        op_nxt    = EXE_OP;
        data_nxt  = EXE_DATA;
        hold_nxt  = hold;
        err_nxt   = ERR;
        done_nxt  = 1'b0;
        case (state)
            S_BOOT: begin
                if (EXE_RDY) state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (START) begin
                    hold_nxt  = HOLD;
                    err_nxt   = 1'b0;
                    step_nxt  = 6'd0;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (cmd_valid) begin
                    op_nxt    = cmd_op;
                    data_nxt  = cmd_data;
                    acc_nxt   = '0;
                    state_nxt = S_ISSUE;
                end else begin
                    state_nxt = S_DONE;
                end
            end
            S_ISSUE: begin
                if (!EXE_RDY) begin
                    op_nxt    = OP_NOP;
                    state_nxt = S_EXEC;
                end else if (acc == ACC_LAST) begin
                    op_nxt    = OP_NOP;
                    err_nxt   = 1'b1;
                    done_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    acc_nxt = acc + 1'b1;
                end
            end
            S_EXEC: begin
                if (EXE_RDY) begin
                    if (step == STEP_LAST) begin
                        state_nxt = S_DONE;
                    end else begin
                        step_nxt  = step + 6'd1;
                        state_nxt = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                done_nxt  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_BOOT;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= S_BOOT;
            step     <= 6'd0;
            acc      <= '0;
            hold     <= 1'b0;
            EXE_ENB  <= 1'b0;
            EXE_OP   <= OP_NOP;
            EXE_DATA <= 8'h00;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            state    <= state_nxt;
            step     <= step_nxt;
            acc      <= acc_nxt;
            hold     <= hold_nxt;
            EXE_ENB  <= 1'b1;
            EXE_OP   <= op_nxt;
            EXE_DATA <= data_nxt;
            DONE     <= done_nxt;
            ERR      <= err_nxt;
        end
    end

    // Buffer only accepts writes while idle so a running refresh sees a stable image.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 32; i++) char_buf[i] <= 8'h20;
        end else if (state == S_IDLE && WR_EN) begin
            char_buf[WR_ADDR] <= WR_DATA;
        end
    end
endmodule

// File: tb/tb_lcd_text_sequencer.sv
// Scoreboard bench for lcd_text_sequencer: behavioural executor, reference command list
// built from the buffer image, monitor popping expected events on each issue / DONE.
module tb_lcd_text_sequencer;
    localparam int TO = 8;

    logic       CLK = 1'b0;
    logic       RST, START, HOLD, WR_EN;
    logic [4:0] WR_ADDR;
    logic [7:0] WR_DATA;
    logic       EXE_RDY, EXE_ENB, BUSY, DONE, ERR;
    logic [3:0] EXE_OP;
    logic [7:0] EXE_DATA;

    logic man_ctl = 1'b1, man_rdy = 1'b0, ex_rdy = 1'b1;
    assign EXE_RDY = man_ctl ? man_rdy : ex_rdy;

    lcd_text_sequencer #(.ACK_TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST), .START(START), .HOLD(HOLD), .WR_EN(WR_EN),
        .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .EXE_RDY(EXE_RDY), .EXE_ENB(EXE_ENB),
        .EXE_OP(EXE_OP), .EXE_DATA(EXE_DATA), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit         done;
        logic [3:0] op;
        logic [7:0] data;
        bit         err;
    } evt_t;

    evt_t       q[$];
    logic [7:0] buf_m [32];
    int vectors = 0, miscompares = 0;
    int cyc = 0, n_issue = 0, issue_cyc = 0, done_cyc = 0;
    int ex_ph = 0, ex_cnt = 0;
    bit mon_en = 1'b0;
    logic [3:0] prev_op = 4'hF;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_evt(input bit dn, input logic [3:0] op, input logic [7:0] d, input bit e);
        evt_t x;
        x.done = dn; x.op = op; x.data = d; x.err = e;
        q.push_back(x);
    endtask

    // Reference: clear, line-1 address, 16 chars, line-2 address, 16 chars, optional wait.
    task automatic push_seq(input bit h);
        push_evt(0, 4'h0, 8'h00, 0);
        push_evt(0, 4'h3, 8'h00, 0);
        for (int i = 0; i < 16; i++) push_evt(0, 4'h1, buf_m[i], 0);
        push_evt(0, 4'h3, 8'h40, 0);
        for (int i = 16; i < 32; i++) push_evt(0, 4'h1, buf_m[i], 0);
        if (h) push_evt(0, 4'h4, 8'h00, 0);
        push_evt(1, 4'hF, 8'h00, 0);
    endtask

    task automatic sb_check(input bit is_done);
        evt_t e;
        vectors++;
        if (q.size() == 0) begin
            miscompares++;
            $display("FAIL sb_unexpected: done=%0b op=%h data=%h, expected no event", is_done, EXE_OP, EXE_DATA);
            return;
        end
        e = q.pop_front();
        if (is_done) begin
            if (!e.done || ERR !== e.err) begin
                miscompares++;
                $display("FAIL sb_done: got done err=%0b, expected %s op=%h err=%0b",
                         ERR, e.done ? "done" : "cmd", e.op, e.err);
            end
        end else if (e.done || EXE_OP !== e.op ||
                     ((e.op == 4'h1 || e.op == 4'h3) && EXE_DATA !== e.data)) begin
            miscompares++;
            $display("FAIL sb_cmd: got op=%h data=%h, expected %s op=%h data=%h",
                     EXE_OP, EXE_DATA, e.done ? "done" : "cmd", e.op, e.data);
        end
    endtask

    // Executor model: RDY falls one cycle after a command is seen, rises 1..4 cycles later.
    always @(posedge CLK) begin
        #1;
        if (!RST || man_ctl) begin
            ex_ph  = 0;
            ex_rdy = 1'b1;
        end else begin
            case (ex_ph)
                0: if (EXE_OP != 4'hF) ex_ph = 1;
                1: begin ex_rdy = 1'b0; ex_cnt = $urandom_range(4, 1); ex_ph = 2; end
                default: begin
                    ex_cnt--;
                    if (ex_cnt == 0) begin ex_rdy = 1'b1; ex_ph = 0; end
                end
            endcase
        end
    end

    always @(negedge CLK) begin
        cyc++;
        if (mon_en) begin
            if (EXE_OP != 4'hF && prev_op == 4'hF) begin
                n_issue++;
                issue_cyc = cyc;
                sb_check(1'b0);
            end
            if (DONE) begin
                done_cyc = cyc;
                sb_check(1'b1);
                chk("done_not_busy", BUSY, 0);
                if (!man_ctl) chk("done_after_rdy", ex_ph, 0);
            end
        end
        prev_op = EXE_OP;
    end

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        @(negedge CLK);
        WR_EN = 1'b1; WR_ADDR = a; WR_DATA = d;
        buf_m[a] = d;
        @(negedge CLK);
        WR_EN = 1'b0;
    endtask

    task automatic go(input bit h, input bit w, input logic [4:0] a, input logic [7:0] d, input bit to_mode);
        @(negedge CLK);
        START = 1'b1; HOLD = h; WR_EN = w; WR_ADDR = a; WR_DATA = d;
        if (w) buf_m[a] = d;
        if (to_mode) begin
            push_evt(0, 4'h0, 8'h00, 0);
            push_evt(1, 4'hF, 8'h00, 1);
        end else begin
            push_seq(h);
        end
        @(negedge CLK);
        START = 1'b0; WR_EN = 1'b0; HOLD = 1'($urandom_range(1, 0));
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (q.size() != 0 && n < bound) begin
            @(negedge CLK);
            n++;
        end
        chk("seq_complete_pending", q.size(), 0);
        q.delete();
        @(negedge CLK);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_enb"}, EXE_ENB, 0);
        chk({tag, "_op"}, EXE_OP, 4'hF);
        chk({tag, "_data"}, EXE_DATA, 8'h00);
        chk({tag, "_busy"}, BUSY, 1);
        chk({tag, "_done"}, DONE, 0);
        chk({tag, "_err"}, ERR, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] hello [5];
        logic [7:0] world [5];
        bit busy_drop;
        int base, n;
        hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        world = '{8'h57, 8'h4F, 8'h52, 8'h4C, 8'h44};
        RST = 1'b0; START = 1'b0; HOLD = 1'b0; WR_EN = 1'b0; WR_ADDR = '0; WR_DATA = '0;
        for (int i = 0; i < 32; i++) buf_m[i] = 8'h20;
        #12;
        chk_reset_vals("reset");

        // Boot: executor not ready for 100 cycles
        @(negedge CLK); RST = 1'b1;
        @(posedge CLK); #1;
        chk("enb_after_reset", EXE_ENB, 1);
        busy_drop = 1'b0;
        repeat (100) begin
            @(negedge CLK);
            if (BUSY !== 1'b1) busy_drop = 1'b1;
        end
        chk("boot_busy_held", busy_drop, 0);
        man_rdy = 1'b1;
        @(negedge CLK);
        chk("boot_to_idle", BUSY, 0);
        man_ctl = 1'b0;
        mon_en  = 1'b1;

        // Full refresh without and with HOLD
        for (int i = 0; i < 5; i++) wr(5'(i), hello[i]);
        for (int i = 0; i < 5; i++) wr(5'(16 + i), world[i]);
        go(1'b0, 1'b0, 5'd0, 8'd0, 1'b0);
        wait_idle(1000);
        chk("full_err", ERR, 0);
        go(1'b1, 1'b0, 5'd0, 8'd0, 1'b0);
        wait_idle(1000);

        // Busy guard: write and START mid-sequence are dropped
        go(1'b0, 1'b0, 5'd0, 8'd0, 1'b0);
        repeat (20) @(negedge CLK);
        chk("guard_busy", BUSY, 1);
        START = 1'b1; WR_EN = 1'b1; WR_ADDR = 5'd0; WR_DATA = 8'hAA;
        @(negedge CLK);
        START = 1'b0; WR_EN = 1'b0;
        wait_idle(1000);
        repeat (30) @(negedge CLK);
        chk("guard_no_restart", BUSY, 0);
        go(1'b0, 1'b0, 5'd0, 8'd0, 1'b0);
        wait_idle(1000);

        // Accept timeout with RDY stuck high
        man_rdy = 1'b1; man_ctl = 1'b1;
        go(1'b0, 1'b0, 5'd0, 8'd0, 1'b1);
        wait_idle(100);
        chk("to_latency", done_cyc - issue_cyc, TO);
        chk("to_op_nop", EXE_OP, 4'hF);
        chk("to_busy", BUSY, 0);
        chk("to_err", ERR, 1);
        man_ctl = 1'b0;
        go(1'b0, 1'b0, 5'd0, 8'd0, 1'b0);
        chk("err_cleared", ERR, 0);
        wait_idle(1000);

        // Random buffer images, HOLD and same-cycle write+START
        repeat (6) begin
            n = $urandom_range(6, 0);
            repeat (n) wr(5'($urandom_range(31, 0)), 8'($urandom));
            go(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
               5'($urandom_range(31, 0)), 8'($urandom), 1'b0);
            wait_idle(1000);
        end

        // Reset while step 10 is being issued
        base = n_issue;
        go(1'b0, 1'b0, 5'd0, 8'd0, 1'b0);
        n = 0;
        while (n_issue < base + 11 && n < 500) begin
            @(negedge CLK);
            n++;
        end
        chk("reached_step10", n_issue - base, 11);
        @(posedge CLK); #2;
        mon_en = 1'b0;
        RST = 1'b0;
        #1;
        chk_reset_vals("midreset");
        q.delete();
        for (int i = 0; i < 32; i++) buf_m[i] = 8'h20;
        man_ctl = 1'b1; man_rdy = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        chk("midreset_boot_busy", BUSY, 1);
        chk("midreset_no_cmd", EXE_OP, 4'hF);
        man_rdy = 1'b1;
        @(negedge CLK);
        chk("midreset_idle", BUSY, 0);
        man_ctl = 1'b0;
        mon_en  = 1'b1;
        go(1'b0, 1'b0, 5'd0, 8'd0, 1'b0);
        wait_idle(1000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/lcd_text_sequencer.md
LCD_TEXT_SEQUENCER -- requirements
Module: lcd_text_sequencer

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 1023, the cycles allowed for the executor to accept a command.
REQ-002 SHALL have the following ports, clock and reset first:
- CLK  input  1  sole clock, rising edge.
- RST  input  1  reset, asynchronous and active-low.
- START  input  1  one-cycle request to refresh the display.
- HOLD  input  1  appends the 2 s wait command to the sequence; sampled with START.
- WR_EN  input  1  character buffer write strobe.
- WR_ADDR  input  5  buffer index; 0-15 is line 1, 16-31 is line 2.
- WR_DATA  input  8  character code.
- EXE_RDY  input  1  executor idle flag.
- EXE_ENB  output  1  executor enable.
- EXE_OP  output  4  executor opcode.
- EXE_DATA  output  8  executor data.
- BUSY  output  1  sequence in progress.
- DONE  output  1  one-cycle pulse at sequence end.
- ERR  output  1  sticky accept-timeout flag.

Function
REQ-003 SHALL hold a 32x8 character buffer; a write with WR_EN=1 in S_IDLE stores WR_DATA at WR_ADDR on the clock edge; a write while BUSY=1 SHALL be ignored.
REQ-004 Opcodes SHALL be: 0 = clear, 1 = write char, 3 = set DDRAM address, 4 = wait 2 s, 4'hF = NOP; EXE_OP SHALL be NOP whenever no command is being issued.
REQ-005 FSM states SHALL be S_BOOT, S_IDLE, S_LOAD, S_ISSUE, S_EXEC, S_DONE.
REQ-006 S_BOOT: wait for EXE_RDY=1 (executor power-up init complete), then go to S_IDLE.
REQ-007 S_IDLE: BUSY=0; START=1 SHALL latch HOLD, clear ERR, clear the 6-bit step counter and go to S_LOAD; BUSY=1 from the following cycle.
REQ-008 S_LOAD SHALL select the command for the step:
- step 0: clear.
- step 1: set address, DATA 8'h00.
- steps 2-17: write buf[step-2].
- step 18: set address, DATA 8'h40.
- steps 19-34: write buf[step-3].
- step 35: wait 2 s if HOLD was latched; otherwise go to S_DONE.
It SHALL drive EXE_OP/EXE_DATA and go to S_ISSUE.
REQ-009 S_ISSUE: hold EXE_OP/EXE_DATA; when EXE_RDY=0 (accepted), set EXE_OP=NOP and go to S_EXEC.
REQ-010 In S_ISSUE an accept counter SHALL increment each cycle; on reaching ACK_TIMEOUT with EXE_RDY still 1, set EXE_OP=NOP, set ERR=1, pulse DONE and go to S_IDLE.
REQ-011 S_EXEC: hold EXE_DATA; on EXE_RDY=1, increment the step counter and go to S_LOAD; no timeout applies.
REQ-012 After step 34 (HOLD=0) or step 35 (HOLD=1) completes, S_DONE SHALL pulse DONE for one cycle and go to S_IDLE.
REQ-013 EXE_DATA SHALL remain stable from S_LOAD through the cycle EXE_RDY returns to 1.
REQ-014 START while BUSY=1 SHALL be ignored; START and WR_EN in the same S_IDLE cycle SHALL perform the write and start the sequence.
REQ-015 The step counter SHALL never exceed 35; ERR SHALL be cleared only by reset or an accepted START.

Reset
REQ-016 While RST=0, all state SHALL clear asynchronously to these values:
- FSM in S_BOOT, BUSY=1.
- EXE_ENB=0, EXE_OP=4'hF, EXE_DATA=8'h00.
- DONE=0, ERR=0, step and accept counters 0.
- all buffer bytes 8'h20.
REQ-017 EXE_ENB SHALL be 1 from the first clock edge after RST deasserts.
REQ-018 Reset asserted mid-sequence SHALL abort immediately to the REQ-016 values; no partial command SHALL be reissued after release.

Verification
REQ-019 The bench SHALL use a behavioural executor model: RDY falls 1 cycle after a valid OP is seen and rises N cycles later. It SHALL cover:
- Boot: hold EXE_RDY=0 for 100 cycles after reset release -> BUSY stays 1; EXE_RDY=1 -> BUSY=0 next cycle.
- Full refresh: write "HELLO" at 0-4 and "WORLD" at 16-20, START with HOLD=0 -> exactly 35 commands in order: clear, addr 00, 16 writes (48,45,4C,4C,4F, then 11 x 20), addr 40, 16 writes; DONE pulses once; ERR=0.
- HOLD: START with HOLD=1 -> 36th command OP=4 issued; DONE only after its RDY returns to 1.
- Timeout: ACK_TIMEOUT=8, EXE_RDY stuck at 1 -> ERR=1 and DONE pulse 8 cycles after issue, EXE_OP=NOP, BUSY=0.
- Busy guard: WR_EN and START during a sequence -> buffer unchanged, no second sequence.
- Reset mid-sequence at step 10 -> outputs at reset values immediately; buffer reads back 8'h20.
